mc_alu: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle datapath ALU, used by the processor's execute stage.
- Adds start/done handshaking, registered outputs, signed/unsigned compare, XOR/NOR, and iterative unsigned multiply and divide.
- Single-cycle ops complete one clock after start. MULU and DIVU take WIDTH+1 clocks; the control unit stalls on busy.

---
 rtl/mc_alu_pkg.sv | 28 ++
 rtl/mc_alu_iter.sv | 69 ++++++
 rtl/mc_alu.sv | 116 +++++++++++
 tb/tb_mc_alu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_alu_pkg.sv
// Shared op encodings, FSM state type and helpers for the multi-cycle ALU.
package mc_alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SUBZ = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MULU = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_NOR  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Ops that may use the iterative engine (DIVU by zero is short-cut by the top)
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mc_alu_iter.sv
// Shared iterative engine: shift-add multiply or restoring shift-subtract divide.
// The accumulator holds {hi, lo}; nxt_* expose the value after the current step
// so the top can register the final answer on the last step without extra delay.
module mc_alu_iter
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mode,      // 0 = multiply, 1 = divide
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] nxt_lo,
    output logic [WIDTH-1:0] nxt_hi,
    output logic             done_iter
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   opnd;
    logic [CNT_W-1:0]   cnt;
    logic               md;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;

    // One multiply or divide step on the accumulator
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // partial remainder shifted left with the next dividend bit brought in
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = {1'b0, shifted} - {2'b00, opnd};
        if (md) begin
            if (diff[WIDTH+1])
                acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    assign nxt_lo    = acc_nxt[WIDTH-1:0];
    assign nxt_hi    = acc_nxt[2*WIDTH-1:WIDTH];
    assign done_iter = (cnt == CNT_W'(1));

    // Operand latch on load, then one step per enabled cycle until the count expires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            opnd <= '0;
            cnt  <= '0;
            md   <= 1'b0;
        end else if (load) begin
            acc  <= {{WIDTH{1'b0}}, a};
            opnd <= b;
            md   <= mode;
            cnt  <= CNT_W'(WIDTH);
        end else if (step && (cnt != '0)) begin
            acc  <= acc_nxt;
            cnt  <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith ops plus iterative
// unsigned multiply and divide, with start/busy/done handshaking.
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div0
);

    state_t           state;
    logic [WIDTH-1:0] sc_res;
    logic             accept;
    logic             b_zero;
    logic             iter_load;
    logic [WIDTH-1:0] it_lo;
    logic [WIDTH-1:0] it_hi;
    logic             it_last;

    assign busy      = (state == ST_MUL) || (state == ST_DIV);
    assign done      = (state == ST_DONE);
    // DONE accepts a new start so back-to-back issue has no bubble
    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign b_zero    = (b == '0);
    assign iter_load = accept && is_multicycle(alu_op) && !((alu_op == OP_DIVU) && b_zero);

    // Single-cycle operation results
    always_comb begin
        sc_res = '0;
        case (alu_op)
            OP_AND:          sc_res = a & b;
            OP_OR:           sc_res = a | b;
            OP_ADD:          sc_res = a + b;
            OP_SUB, OP_SUBZ: sc_res = a - b;
            OP_SLT:          sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:         sc_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_XOR:          sc_res = a ^ b;
            OP_NOR:          sc_res = ~(a | b);
            default:         sc_res = '0;
        endcase
    end

    mc_alu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (iter_load),
        .mode      (alu_op == OP_DIVU),
        .step      (busy),
        .a         (a),
        .b         (b),
        .nxt_lo    (it_lo),
        .nxt_hi    (it_hi),
        .done_iter (it_last)
    );

    // Control FSM and output registers; outputs hold until the next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            result <= '0;
            hi     <= '0;
            zero   <= 1'b0;
            div0   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        if (alu_op == OP_MULU) begin
                            state <= ST_MUL;
                        end else if (alu_op == OP_DIVU) begin
                            if (b_zero) begin
                                result <= '1;
                                hi     <= a;
                                zero   <= 1'b0;
                                div0   <= 1'b1;
                                state  <= ST_DONE;
                            end else begin
                                state <= ST_DIV;
                            end
                        end else begin
                            result <= sc_res;
                            hi     <= '0;
                            zero   <= (sc_res == '0);
                            div0   <= 1'b0;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (it_last) begin
                        result <= it_lo;
                        hi     <= it_hi;
                        zero   <= (it_lo == '0);
                        div0   <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu at WIDTH=32, plus a WIDTH=8 multiply regression.
module tb_mc_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, zero, div0;
    logic [31:0] result, hi;

    logic        start8 = 1'b0;
    logic [3:0]  op8 = 4'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, zero8, div08;
    logic [7:0]  result8, hi8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .hi(hi), .zero(zero), .div0(div0)
    );

    mc_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .alu_op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .hi(hi8), .zero(zero8), .div0(div08)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op for cycle 0; returns positioned 1 ns into cycle 1
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; alu_op = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count cycles until done (sampled mid-cycle); lat = -1 on timeout
    task automatic wait_done(input int from, output int lat, output int nbusy);
        bit hit = 0;
        nbusy = 0;
        lat = from;
        while (!hit && lat < 200) begin
            @(negedge clk);
            if (done) hit = 1;
            else begin
                if (busy) nbusy++;
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!hit) lat = -1;
    endtask

    initial begin
        int lat, nb;

        // reset state
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_flags", {30'd0, zero, div0}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD wraps
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
        wait_done(1, lat, nb);
        chk("add_lat", 32'(lat), 32'd1);
        chk("add_res", result, 32'd0);
        chk("add_zero", {31'd0, zero}, 32'd1);
        chk("add_hi", hi, 32'd0);
        @(posedge clk); #1;

        // SUBZ equal operands
        issue(4'b0111, 32'd5, 32'd5);
        wait_done(1, lat, nb);
        chk("subz_res", result, 32'd0);
        chk("subz_zero", {31'd0, zero}, 32'd1);
        @(posedge clk); #1;

        // SLT signed vs SLTU
        issue(4'b1000, 32'hFFFF_FFFF, 32'd1);
        wait_done(1, lat, nb);
        chk("slt_res", result, 32'd1);
        chk("slt_zero", {31'd0, zero}, 32'd0);
        @(posedge clk); #1;
        issue(4'b1001, 32'hFFFF_FFFF, 32'd1);
        wait_done(1, lat, nb);
        chk("sltu_res", result, 32'd0);
        @(posedge clk); #1;

        // XOR / NOR
        issue(4'b1100, 32'hFF00_FF00, 32'h0FF0_0FF0);
        wait_done(1, lat, nb);
        chk("xor_res", result, 32'hF0F0_F0F0);
        @(posedge clk); #1;
        issue(4'b1101, 32'hFF00_FF00, 32'h0FF0_0FF0);
        wait_done(1, lat, nb);
        chk("nor_res", result, 32'h000F_000F);
        @(posedge clk); #1;

        // MULU
        issue(4'b1010, 32'hFFFF_FFFF, 32'd2);
        wait_done(1, lat, nb);
        chk("mul_lat", 32'(lat), 32'd33);
        chk("mul_busy", 32'(nb), 32'd32);
        chk("mul_res", result, 32'hFFFF_FFFE);
        chk("mul_hi", hi, 32'd1);
        chk("mul_zero", {31'd0, zero}, 32'd0);
        chk("mul_done_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // DIVU
        issue(4'b1011, 32'd100, 32'd7);
        wait_done(1, lat, nb);
        chk("div_lat", 32'(lat), 32'd33);
        chk("div_res", result, 32'd14);
        chk("div_hi", hi, 32'd2);
        chk("div_div0", {31'd0, div0}, 32'd0);
        @(posedge clk); #1;

        // DIVU by zero
        issue(4'b1011, 32'd9, 32'd0);
        wait_done(1, lat, nb);
        chk("div0_lat", 32'(lat), 32'd1);
        chk("div0_res", result, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'd9);
        chk("div0_flag", {31'd0, div0}, 32'd1);
        @(posedge clk); #1;
        // outputs hold after done
        chk("hold_res", result, 32'hFFFF_FFFF);

        // start while busy is ignored; operands changed too
        issue(4'b1010, 32'h1234_5678, 32'h10);
        repeat (4) begin @(posedge clk); #1; end
        issue(4'b0010, 32'd1, 32'd1);
        a = 32'hDEAD_BEEF; b = 32'h5555_5555;
        wait_done(6, lat, nb);
        chk("ign_lat", 32'(lat), 32'd33);
        chk("ign_res", result, 32'h2345_6780);
        chk("ign_hi", hi, 32'd1);
        chk("ign_div0_clr", {31'd0, div0}, 32'd0);
        // back-to-back start in the DONE cycle
        start = 1'b1; alu_op = 4'b0010; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_res", result, 32'd7);
        @(posedge clk); #1;

        // reset in the middle of a divide
        issue(4'b1011, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_res", result, 32'd0);
        chk("ar_hi", hi, 32'd0);
        nb = 0;
        repeat (40) begin @(negedge clk); if (done) nb++; end
        rst_n = 1'b1;
        repeat (30) begin @(negedge clk); if (done) nb++; end
        chk("ar_no_done", 32'(nb), 32'd0);
        @(posedge clk); #1;
        issue(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
        wait_done(1, lat, nb);
        chk("and_lat", 32'(lat), 32'd1);
        chk("and_res", result, 32'h0000_00F0);
        @(posedge clk); #1;

        // illegal opcode
        issue(4'b0101, 32'h1234, 32'h5678);
        wait_done(1, lat, nb);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_res", result, 32'd0);
        chk("ill_hi", hi, 32'd0);
        chk("ill_zero", {31'd0, zero}, 32'd1);
        @(posedge clk); #1;

        // WIDTH=8 multiply regression
        start8 = 1'b1; op8 = 4'b1010; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        begin
            bit hit = 0;
            while (!hit && lat < 50) begin
                @(negedge clk);
                if (done8) hit = 1;
                else begin @(posedge clk); #1; lat++; end
            end
            if (!hit) lat = -1;
        end
        chk("w8_lat", 32'(lat), 32'd9);
        chk("w8_res", {24'd0, result8}, 32'h01);
        chk("w8_hi", {24'd0, hi8}, 32'hFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
